// File: rtl/tetris_pkg.sv
// Shared types for the falling-block game: move encoding, scheduler states,
// request slot indices (in arbitration priority order) and arbitration helpers.
package tetris_pkg;

    typedef enum logic [2:0] {
        RIGHT = 3'd0,
        LEFT  = 3'd1,
        ROR   = 3'd2,
        ROL   = 3'd3,
        DOWN  = 3'd4
    } move_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_ISSUE = 2'd2
    } sched_state_t;

    // Lower index wins arbitration.
    localparam int unsigned NUM_REQ   = 6;
    localparam int unsigned REQ_GRAV  = 0;
    localparam int unsigned REQ_ROR   = 1;
    localparam int unsigned REQ_ROL   = 2;
    localparam int unsigned REQ_LEFT  = 3;
    localparam int unsigned REQ_RIGHT = 4;
    localparam int unsigned REQ_UDOWN = 5;

    // Isolate the lowest set bit, i.e. the highest-priority pending request.
    function automatic logic [NUM_REQ-1:0] first_set(input logic [NUM_REQ-1:0] v);
        return v & (~v + NUM_REQ'(1));
    endfunction

    // Map a one-hot winner to its move; both gravity and user DOWN map to DOWN.
    function automatic move_t req_to_move(input logic [NUM_REQ-1:0] win);
        move_t m;
        if (win[REQ_ROR]) begin
            m = ROR;
        end else if (win[REQ_ROL]) begin
            m = ROL;
        end else if (win[REQ_LEFT]) begin
            m = LEFT;
        end else if (win[REQ_RIGHT]) begin
            m = RIGHT;
        end else begin
            m = DOWN;
        end
        return m;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Per-button request generator: one-cycle pulse on a rising edge, plus optional
// auto-repeat pulses after DAS_DELAY held cycles and every DAS_RATE cycles thereafter.
module btn_repeat #(
    parameter int unsigned DAS_DELAY = 8,
    parameter int unsigned DAS_RATE  = 2,
    parameter bit          REPEAT    = 1'b0
) (
    input  logic clk,
    input  logic nrst,
    input  logic btn,
    output logic req
);

    logic prev_r;
    logic edge_s;
    logic rpt_s;

    assign edge_s = btn & ~prev_r;
    assign req    = edge_s | rpt_s;

    // Edge history of the button level.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= btn;
        end
    end

    // Repeat logic exists only when requested and the timing is sensible.
    if (REPEAT && (DAS_DELAY >= 2) && (DAS_RATE >= 1) && (DAS_RATE <= DAS_DELAY)) begin : g_rpt
        localparam int unsigned HW = $clog2(DAS_DELAY + 1);
        // hold_r equals the index of the current held cycle (edge cycle is 0).
        logic [HW-1:0] hold_r;

        assign rpt_s = btn & prev_r & (hold_r == HW'(DAS_DELAY - 1));

        // Held-cycle counter; reloading on a repeat spaces the next one DAS_RATE later.
        always_ff @(posedge clk) begin
            if (!nrst) begin
                hold_r <= {HW{1'b0}};
            end else if (!btn) begin
                hold_r <= {HW{1'b0}};
            end else if (!prev_r) begin
                hold_r <= HW'(1);
            end else if (rpt_s) begin
                hold_r <= HW'(DAS_DELAY - DAS_RATE);
            end else begin
                hold_r <= hold_r + HW'(1);
            end
        end
    end else begin : g_edge_only
        assign rpt_s = 1'b0;
    end

endmodule

// File: rtl/move_scheduler.sv
// Move scheduler: turns button edges and the gravity timer into a ready/valid move stream.
// Build option: define AUTO_REPEAT_EN to auto-repeat held LEFT, RIGHT and DOWN buttons.
module move_scheduler
    import tetris_pkg::*;
#(
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned DROP_PERIOD = 1_000_000,
    parameter int unsigned DAS_DELAY   = 8,
    parameter int unsigned DAS_RATE    = 2
) (
    input  logic  clk,
    input  logic  nrst,
    input  logic  en,
    input  logic  btn_right,
    input  logic  btn_left,
    input  logic  btn_ror,
    input  logic  btn_rol,
    input  logic  btn_down,
    output logic  mv_valid,
    output move_t mv,
    output logic  mv_src,
    input  logic  mv_ready
);

`ifdef AUTO_REPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    sched_state_t       state_r;
    sched_state_t       state_next_s;
    logic [NUM_REQ-1:0] req_s;
    logic [NUM_REQ-1:0] pend_r;
    logic [NUM_REQ-1:0] pend_next_s;
    logic [NUM_REQ-1:0] pend_clr_s;
    logic [NUM_REQ-1:0] grav_kill_s;
    logic [NUM_REQ-1:0] win_s;
    logic [CNT_W-1:0]   grav_cnt_r;
    logic [CNT_W-1:0]   grav_cnt_next_s;
    logic               tick_s;
    logic               xfer_s;
    logic               udown_acc_s;
    move_t              mv_next_s;
    logic               src_next_s;

    btn_repeat #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE), .REPEAT(1'b0)) u_ror (
        .clk(clk), .nrst(nrst), .btn(btn_ror), .req(req_s[REQ_ROR])
    );
    btn_repeat #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE), .REPEAT(1'b0)) u_rol (
        .clk(clk), .nrst(nrst), .btn(btn_rol), .req(req_s[REQ_ROL])
    );
    btn_repeat #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE), .REPEAT(RPT_EN)) u_left (
        .clk(clk), .nrst(nrst), .btn(btn_left), .req(req_s[REQ_LEFT])
    );
    btn_repeat #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE), .REPEAT(RPT_EN)) u_right (
        .clk(clk), .nrst(nrst), .btn(btn_right), .req(req_s[REQ_RIGHT])
    );
    btn_repeat #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE), .REPEAT(RPT_EN)) u_down (
        .clk(clk), .nrst(nrst), .btn(btn_down), .req(req_s[REQ_UDOWN])
    );

    assign tick_s          = (grav_cnt_r == CNT_W'(DROP_PERIOD - 1));
    assign req_s[REQ_GRAV] = tick_s;
    assign xfer_s          = mv_valid & mv_ready;
    assign udown_acc_s     = xfer_s & (mv == DOWN) & ~mv_src;
    assign win_s           = first_set(pend_r);

    // Pending flags and gravity timer; an accepted user DOWN restarts the drop interval.
    always_comb begin
        grav_kill_s = {{(NUM_REQ-1){1'b0}}, udown_acc_s};
        pend_next_s = ((pend_r & ~pend_clr_s) | req_s) & ~grav_kill_s;
        if (tick_s || udown_acc_s) begin
            grav_cnt_next_s = {CNT_W{1'b0}};
        end else begin
            grav_cnt_next_s = grav_cnt_r + CNT_W'(1);
        end
    end

    // Next-state and winner selection.
    always_comb begin
        state_next_s = state_r;
        mv_next_s    = mv;
        src_next_s   = mv_src;
        pend_clr_s   = {NUM_REQ{1'b0}};
        case (state_r)
            S_IDLE: begin
                if (en) begin
                    state_next_s = S_ARB;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ARB: begin
                if (!en) begin
                    state_next_s = S_IDLE;
                end else if (|pend_r) begin
                    state_next_s = S_ISSUE;
                    mv_next_s    = req_to_move(win_s);
                    src_next_s   = win_s[REQ_GRAV];
                    pend_clr_s   = win_s;
                end else begin
                    state_next_s = S_ARB;
                end
            end
            S_ISSUE: begin
                // A valid is never withdrawn; a low en only takes effect after transfer.
                if (xfer_s) begin
                    if (en) begin
                        state_next_s = S_ARB;
                    end else begin
                        state_next_s = S_IDLE;
                    end
                end else begin
                    state_next_s = S_ISSUE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State, output and bookkeeping registers; IDLE holds the timer and flags at zero.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r    <= S_IDLE;
            pend_r     <= {NUM_REQ{1'b0}};
            grav_cnt_r <= {CNT_W{1'b0}};
            mv_valid   <= 1'b0;
            mv         <= RIGHT;
            mv_src     <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            mv_valid <= (state_next_s == S_ISSUE);
            mv       <= mv_next_s;
            mv_src   <= src_next_s;
            if (state_r == S_IDLE) begin
                pend_r     <= {NUM_REQ{1'b0}};
                grav_cnt_r <= {CNT_W{1'b0}};
            end else begin
                pend_r     <= pend_next_s;
                grav_cnt_r <= grav_cnt_next_s;
            end
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the scheduling rules.
module tb_move_scheduler;
    import tetris_pkg::*;

    localparam int DP = 16;
    localparam int DD = 6;
    localparam int DR = 2;
`ifdef AUTO_REPEAT_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif

    logic  clk = 1'b0;
    logic  nrst = 1'b0;
    logic  en = 1'b0;
    logic  btn_right = 1'b0, btn_left = 1'b0, btn_ror = 1'b0, btn_rol = 1'b0, btn_down = 1'b0;
    logic  mv_ready = 1'b1;
    logic  mv_valid;
    move_t mv;
    logic  mv_src;

    move_scheduler #(.CNT_W(8), .DROP_PERIOD(DP), .DAS_DELAY(DD), .DAS_RATE(DR)) dut (
        .clk(clk), .nrst(nrst), .en(en),
        .btn_right(btn_right), .btn_left(btn_left), .btn_ror(btn_ror),
        .btn_rol(btn_rol), .btn_down(btn_down),
        .mv_valid(mv_valid), .mv(mv), .mv_src(mv_src), .mv_ready(mv_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {logic [2:0] m; logic s; int c;} xfer_t;
    xfer_t xfer_q[$];
    int n_assert = 0;
    int n_fail = 0;
    int cyc_n = 0;
    int valid_seen = 0;

    // Reference model: game running flag, offered move, pending set, drop timer, button history.
    bit       m_active = 1'b0;
    bit       m_valid = 1'b0;
    move_t    m_mv = RIGHT;
    bit       m_src = 1'b0;
    bit [5:0] m_pend = 6'd0;
    int       m_cnt = 0;
    bit       m_prev[5];
    int       m_held[5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [4:0] b;
        bit [5:0] req;
        int win;
        int held;
        bit xfer;
        bit udown;
        bit tick;
        int nxt_cnt;
        b = {btn_down, btn_right, btn_left, btn_rol, btn_ror};
        req = 6'd0;
        for (int k = 0; k < 5; k++) begin
            held = b[k] ? m_held[k] + 1 : 0;
            if (b[k] && !m_prev[k]) req[k+1] = 1'b1;
            if (RPT && k >= 2 && held >= DD && ((held - DD) % DR) == 0) req[k+1] = 1'b1;
            m_held[k] = held;
            m_prev[k] = b[k];
        end
        if (!nrst) begin
            m_active = 1'b0; m_valid = 1'b0; m_mv = RIGHT; m_src = 1'b0;
            m_pend = 6'd0; m_cnt = 0;
            for (int k = 0; k < 5; k++) begin
                m_held[k] = 0;
                m_prev[k] = 1'b0;
            end
        end else if (!m_active) begin
            m_pend = 6'd0;
            m_cnt = 0;
            m_active = en;
        end else begin
            xfer = m_valid && mv_ready;
            udown = xfer && (m_mv == DOWN) && !m_src;
            tick = (m_cnt == DP - 1);
            req[0] = tick;
            nxt_cnt = (tick || udown) ? 0 : m_cnt + 1;
            win = -1;
            if (m_valid) begin
                if (xfer) begin
                    m_valid = 1'b0;
                    if (!en) m_active = 1'b0;
                end
            end else if (!en) begin
                m_active = 1'b0;
            end else begin
                for (int i = 5; i >= 0; i--) if (m_pend[i]) win = i;
                if (win >= 0) begin
                    m_valid = 1'b1;
                    m_src = (win == 0);
                    case (win)
                        1: m_mv = ROR;
                        2: m_mv = ROL;
                        3: m_mv = LEFT;
                        4: m_mv = RIGHT;
                        default: m_mv = DOWN;
                    endcase
                end
            end
            for (int i = 0; i < 6; i++) m_pend[i] = (m_pend[i] && i != win) || req[i];
            if (udown) m_pend[0] = 1'b0;
            m_cnt = nxt_cnt;
        end
    endtask

    task automatic cyc();
        if (nrst && mv_valid && mv_ready) xfer_q.push_back('{mv, mv_src, cyc_n});
        model_step();
        @(posedge clk);
        #1;
        cyc_n++;
        chk("valid", mv_valid, m_valid);
        chk("mv", mv, m_mv);
        chk("src", mv_src, m_src);
        if (mv_valid) valid_seen++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_cnt(input int target);
        for (int i = 0; i < 40 && m_cnt != target; i++) cyc();
        chk("wait_cnt_timeout", m_cnt, target);
    endtask

    initial begin
        int rights;

        // Reset state.
        run(3);
        chk("rst_valid", mv_valid, 1'b0);
        chk("rst_mv", mv, RIGHT);
        chk("rst_src", mv_src, 1'b0);

        // Gravity only: DOWN from gravity every DROP_PERIOD cycles.
        nrst = 1'b1; en = 1'b1; mv_ready = 1'b1;
        xfer_q.delete();
        run(70);
        chk("grav_count", xfer_q.size(), 4);
        for (int i = 0; i < xfer_q.size(); i++) begin
            chk("grav_mv", xfer_q[i].m, DOWN);
            chk("grav_src", xfer_q[i].s, 1'b1);
            if (i > 0) chk("grav_gap", xfer_q[i].c - xfer_q[i-1].c, DP);
        end

        // ROR, LEFT and a gravity tick in the same cycle.
        wait_cnt(DP - 1);
        btn_ror = 1'b1; btn_left = 1'b1;
        xfer_q.delete();
        cyc();
        btn_ror = 1'b0; btn_left = 1'b0;
        run(7);
        chk("prio_count", xfer_q.size(), 3);
        if (xfer_q.size() == 3) begin
            chk("prio0_mv", xfer_q[0].m, DOWN);
            chk("prio0_src", xfer_q[0].s, 1'b1);
            chk("prio1_mv", xfer_q[1].m, ROR);
            chk("prio2_mv", xfer_q[2].m, LEFT);
            chk("prio2_src", xfer_q[2].s, 1'b0);
            chk("prio_gap1", xfer_q[1].c - xfer_q[0].c, 2);
            chk("prio_gap2", xfer_q[2].c - xfer_q[1].c, 2);
        end

        // Back-pressure: LEFT held stable, en dropped mid-wait.
        mv_ready = 1'b0; btn_left = 1'b1;
        cyc();
        btn_left = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", mv_valid, 1'b1);
            chk("stall_mv", mv, LEFT);
            if (i == 2) en = 1'b0;
            cyc();
        end
        xfer_q.delete();
        mv_ready = 1'b1;
        cyc();
        chk("stall_xfer_count", xfer_q.size(), 1);
        if (xfer_q.size() == 1) chk("stall_xfer_mv", xfer_q[0].m, LEFT);
        valid_seen = 0;
        run(20);
        chk("idle_no_move", valid_seen, 0);

        // User DOWN accepted at counter 10 restarts the drop interval.
        en = 1'b1;
        wait_cnt(8);
        btn_down = 1'b1;
        cyc();
        btn_down = 1'b0;
        xfer_q.delete();
        run(24);
        chk("udown_count", xfer_q.size(), 2);
        if (xfer_q.size() == 2) begin
            chk("udown_mv", xfer_q[0].m, DOWN);
            chk("udown_src", xfer_q[0].s, 1'b0);
            chk("udown_grav_src", xfer_q[1].s, 1'b1);
            chk("udown_to_grav_gap", xfer_q[1].c - xfer_q[0].c, DP + 2);
        end

        // RIGHT held for 12 cycles.
        en = 1'b0;
        run(2);
        en = 1'b1;
        cyc();
        btn_right = 1'b1;
        xfer_q.delete();
        run(12);
        btn_right = 1'b0;
        run(4);
        rights = 0;
        foreach (xfer_q[i]) if (xfer_q[i].m == RIGHT && xfer_q[i].s == 1'b0) rights++;
        chk("hold_right_moves", rights, RPT ? 5 : 1);

        // Reset during a pending handshake.
        mv_ready = 1'b0;
        run(2);
        chk("pre_rst_valid", mv_valid, 1'b1);
        nrst = 1'b0;
        cyc();
        chk("mid_rst_valid", mv_valid, 1'b0);
        chk("mid_rst_mv", mv, RIGHT);
        chk("mid_rst_src", mv_src, 1'b0);
        nrst = 1'b1; en = 1'b0; mv_ready = 1'b1;
        valid_seen = 0;
        run(20);
        chk("post_rst_quiet", valid_seen, 0);
        en = 1'b1;
        cyc();
        btn_ror = 1'b1;
        xfer_q.delete();
        cyc();
        btn_ror = 1'b0;
        run(4);
        chk("post_rst_move", xfer_q.size(), 1);
        if (xfer_q.size() == 1) chk("post_rst_mv", xfer_q[0].m, ROR);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            nrst = ($urandom_range(0, 99) != 0);
            en = ($urandom_range(0, 19) != 0);
            mv_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) btn_right = ~btn_right;
            if ($urandom_range(0, 7) == 0) btn_left = ~btn_left;
            if ($urandom_range(0, 7) == 0) btn_ror = ~btn_ror;
            if ($urandom_range(0, 7) == 0) btn_rol = ~btn_rol;
            if ($urandom_range(0, 7) == 0) btn_down = ~btn_down;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset, with ports named clk and nrst.
REQ-002 SHALL have parameter CNT_W, default 24: gravity counter width.
REQ-003 SHALL have parameter DROP_PERIOD, default 1_000_000: cycles between gravity DOWN requests; legal range 2 to 2^CNT_W-1.
REQ-004 SHALL have parameter DAS_DELAY, default 8: hold cycles before auto-repeat starts; used only with AUTO_REPEAT_EN.
REQ-005 SHALL have parameter DAS_RATE, default 2: cycles between auto-repeats; used only with AUTO_REPEAT_EN.
REQ-006 SHALL have port clk, input, 1: rising-edge clock.
REQ-007 SHALL have port nrst, input, 1: synchronous, active-low reset.
REQ-008 SHALL have port en, input, 1: game controller is in a falling-block state.
REQ-009 SHALL have ports btn_right, btn_left, btn_ror, btn_rol, btn_down, input, 1 each: synchronized, debounced button levels.
REQ-010 SHALL have port mv_valid, output, 1: move command valid.
REQ-011 SHALL have port mv, output, move_t (3): move command.
REQ-012 SHALL have port mv_src, output, 1: 0 = user, 1 = gravity.
REQ-013 SHALL have port mv_ready, input, 1: consumer accepts mv.

Function
REQ-014 SHALL set a per-move pending flag on a button rising edge; the flag is visible the cycle after the edge.
REQ-015 SHALL coalesce pending flags: an edge on an already-pending move is a no-op.
REQ-016 SHALL use a gravity counter that increments each cycle outside IDLE.
REQ-017 SHALL, when the gravity counter reaches DROP_PERIOD-1, wrap it to 0 and set gravity_pend; a tick while gravity_pend is set is coalesced.
REQ-018 SHALL implement FSM states S_IDLE, S_ARB and S_ISSUE, with reset state S_IDLE.
REQ-019 SHALL transition S_IDLE->S_ARB when en=1; S_IDLE holds the gravity counter and all pending flags at 0.
REQ-020 SHALL, in S_ARB with any flag pending, register the winner into mv/mv_src, clear the winner's flag, and go to S_ISSUE; with none pending, stay in S_ARB.
REQ-021 SHALL arbitrate with fixed priority: gravity DOWN > ROR > ROL > LEFT > RIGHT > user DOWN.
REQ-022 SHALL drive mv_valid=1 only in S_ISSUE and hold mv/mv_src stable until mv_valid&mv_ready; on transfer, go to S_ARB, giving throughput of at most 1 move per 2 cycles.
REQ-023 SHALL, when en falls in S_ARB, go to S_IDLE next edge; in S_ISSUE the valid is never retracted, and S_IDLE is entered after the transfer completes.
REQ-024 SHALL, on acceptance of a user DOWN, reset the gravity counter to 0 and clear gravity_pend.
REQ-025 SHALL, on simultaneous LEFT and RIGHT edges, set both flags and issue LEFT then RIGHT.
REQ-026 SHALL allow a new edge on a move whose command is in S_ISSUE to re-pend that move.

Reset
REQ-027 SHALL, while nrst=0 at a clock edge, drive mv_valid=0, mv=RIGHT (3'd0), mv_src=0, state=S_IDLE, and clear all pending flags, the gravity counter, edge history and repeat counters.
REQ-028 SHALL, when reset is asserted mid-handshake, drop mv_valid at that edge without waiting for mv_ready.

Configuration
REQ-029 SHALL, with AUTO_REPEAT_EN defined, re-pend LEFT, RIGHT or down (user DOWN) after the button has been held DAS_DELAY cycles, then every DAS_RATE cycles while held; release clears the repeat counter.
REQ-030 SHALL, without AUTO_REPEAT_EN, generate pending flags only from edges, and SHALL NOT instantiate DAS_DELAY/DAS_RATE logic.

Structure
REQ-031 SHALL import move_t from tetris_pkg; sched_state_t (S_IDLE, S_ARB, S_ISSUE) is added to tetris_pkg.
REQ-032 SHALL use sub-module btn_repeat (edge detect plus optional auto-repeat, one instance per button) to produce a 1-cycle request pulse.

Verification
REQ-033 SHALL cover: DROP_PERIOD=16, en=1, mv_ready=1, no buttons -> mv=DOWN, mv_src=1 every 16 cycles.
REQ-034 SHALL cover: btn_ror, btn_left and a gravity tick pending in the same cycle -> issue order DOWN(src=1), ROR, LEFT, with successive mv_valid pulses 2 cycles apart.
REQ-035 SHALL cover: mv_ready=0 for 5 cycles with a LEFT issued -> mv_valid and mv=LEFT held stable for 5 cycles; en dropped mid-wait -> transfer completes, then S_IDLE.
REQ-036 SHALL cover: user DOWN accepted at counter=10 (DROP_PERIOD=16) -> next gravity DOWN issued 16 cycles later, not 6.
REQ-037 SHALL cover: AUTO_REPEAT_EN, DAS_DELAY=6, DAS_RATE=2, btn_right held 12 cycles -> 1 edge move plus 4 repeat RIGHTs; without the macro -> 1 RIGHT.
REQ-038 SHALL cover: nrst=0 asserted while mv_valid=1 -> mv_valid=0 next edge, and no further move until en=1 and a new edge or tick.
